// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// producers. Packet locking keeps a multi-byte message from one requester
// contiguous. It drives the UART send handshake: data set up, wait for busy
// low, send high until busy high, then send low.
//
// Ports
//   ipClk       clock
//   rst         synchronous active-high reset
//   ipReqValid  per-requester byte valid, held until the matching opReqReady
//   ipReqData   requester i byte in bits [8i+7:8i]
//   ipReqLast   byte is the last of its packet
//   opReqReady  one-cycle pulse: requester byte consumed
//   opGrant     one-hot current owner, 0 when none
//   opTxData    byte to UART
//   opTxSend    UART send strobe
//   ipTxBusy    UART transmission in progress
//   opErr       one-cycle pulse on send timeout
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | arbitrate, or wait for the locked owner's next byte
// CAPTURE   | consume owner byte into opTxData, remember its last flag
// WAIT_FREE | hold data until the UART is not busy
// SEND      | assert send until busy rises, or give up on timeout
// RELEASE   | drop send; keep or clear the packet lock
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int SEND_TIMEOUT = 15
) (
  input  logic               ipClk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   ipReqValid,
  input  logic [8*N_REQ-1:0] ipReqData,
  input  logic [N_REQ-1:0]   ipReqLast,
  output logic [N_REQ-1:0]   opReqReady,
  output logic [N_REQ-1:0]   opGrant,
  output logic [7:0]         opTxData,
  output logic               opTxSend,
  input  logic               ipTxBusy,
  output logic               opErr
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(SEND_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_FREE,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t           r_state, w_state_n;
  logic [PW-1:0]    r_ptr, w_ptr_n;
  logic [N_REQ-1:0] r_grant, w_grant_n;
  logic             r_lock, w_lock_n;
  logic             r_last, w_last_n;
  logic [7:0]       r_data, w_data_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_err, w_err_n;

  logic [7:0]       w_bytes [N_REQ];
  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = ipReqData[8*g +: 8];
  end

  // Scan pointer+1, pointer+2, ... so the last winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && ipReqValid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_grant_n = r_grant;
    w_lock_n  = r_lock;
    w_last_n  = r_last;
    w_data_n  = r_data;
    w_cnt_n   = r_cnt;
    w_err_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_lock) begin
          if (ipReqValid[r_ptr]) w_state_n = S_CAPTURE;
        end else if (w_found) begin
          w_grant_n        = '0;
          w_grant_n[w_win] = 1'b1;
          w_ptr_n          = w_win;
          w_state_n        = S_CAPTURE;
        end else begin
          w_grant_n = '0;
        end
      end
      S_CAPTURE: begin
        w_data_n  = w_bytes[r_ptr];
        w_last_n  = ipReqLast[r_ptr];
        w_state_n = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        if (!ipTxBusy) begin
          w_cnt_n   = '0;
          w_state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (ipTxBusy) begin
          // Grant/lock are updated on the way into RELEASE so opGrant
          // already reads 0 during RELEASE at the end of a packet.
          w_state_n = S_RELEASE;
          if (r_last) begin
            w_grant_n = '0;
            w_lock_n  = 1'b0;
          end else begin
            w_lock_n  = 1'b1;
          end
        end else if (r_cnt == CW'(SEND_TIMEOUT - 1)) begin
          w_err_n   = 1'b1;
          w_grant_n = '0;
          w_lock_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_RELEASE: w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(N_REQ - 1);
      r_grant <= '0;
      r_lock  <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_grant <= w_grant_n;
      r_lock  <= w_lock_n;
      r_last  <= w_last_n;
      r_data  <= w_data_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
    end
  end

  assign opReqReady = (r_state == S_CAPTURE) ? r_grant : '0;
  assign opGrant    = r_grant;
  assign opTxData   = r_data;
  assign opTxSend   = (r_state == S_SEND);
  assign opErr      = r_err;

endmodule
